// File: rtl/clkgen_multi.sv
// Multi-channel tick / square-wave generator with runtime divisors that are
// swapped in glitch-free at the channel wrap, plus optional channel cascading.
module clkgen_multi #(
   parameter int                   NCH      = 3,
   parameter int                   WIDTH    = 26,
   parameter logic [NCH*WIDTH-1:0] DIV_INIT = {26'd50000000, 26'd25000000, 26'd50000},
   parameter bit                   CASCADE  = 1'b0,
   localparam int                  SELW     = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             SYNC,
   input  logic             DIV_WE,
   input  logic [SELW-1:0]  DIV_SEL,
   input  logic [WIDTH-1:0] DIV_DATA,
   output logic [NCH-1:0]   TICK,
   output logic [NCH-1:0]   SQW,
   output logic [NCH-1:0]   DIV_PEND
);

   logic [WIDTH-1:0] cnt     [NCH];
   logic [WIDTH-1:0] dact    [NCH];
   logic [WIDTH-1:0] dsh     [NCH];
   logic [WIDTH-1:0] cnt_nxt [NCH];
   logic [NCH-1:0]   adv;
   logic [NCH-1:0]   wrap;
   logic [NCH-1:0]   wr_hit;
   logic             carry;

   // High for the upper floor(D/2) counts of the period; D=0 keeps the output low.
   function automatic logic sqw_level(input logic [WIDTH-1:0] cnt_n,
                                      input logic [WIDTH-1:0] d);
      return (d != '0) && (cnt_n >= (d - (d >> 1)));
   endfunction

   // Walk the channels in order so a cascaded channel sees its parent's wrap
   // from the same cycle without forming a combinational loop on one vector.
   always_comb begin
      carry  = 1'b1;
      adv    = '0;
      wrap   = '0;
      wr_hit = '0;
      for (int i = 0; i < NCH; i++) begin
         cnt_nxt[i] = cnt[i];
         adv[i]     = EN && (!CASCADE || carry);
         wrap[i]    = adv[i] && (dact[i] != '0) && (cnt[i] == dact[i] - 1'b1);
         wr_hit[i]  = DIV_WE && (DIV_SEL == SELW'(i));
         if (dact[i] == '0)
            cnt_nxt[i] = '0;
         else if (wrap[i])
            cnt_nxt[i] = '0;
         else if (adv[i])
            cnt_nxt[i] = cnt[i] + 1'b1;
         carry = wrap[i];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NCH; i++) begin
            cnt[i]  <= '0;
            dact[i] <= DIV_INIT[i*WIDTH +: WIDTH];
            dsh[i]  <= DIV_INIT[i*WIDTH +: WIDTH];
         end
         TICK     <= '0;
         SQW      <= '0;
         DIV_PEND <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (SYNC) begin
               // Phase restart: a write in the same cycle becomes active at once.
               cnt[i]      <= '0;
               TICK[i]     <= 1'b0;
               SQW[i]      <= 1'b0;
               DIV_PEND[i] <= 1'b0;
               if (wr_hit[i]) begin
                  dsh[i]  <= DIV_DATA;
                  dact[i] <= DIV_DATA;
               end else begin
                  dact[i] <= dsh[i];
               end
            end else begin
               cnt[i]  <= cnt_nxt[i];
               TICK[i] <= wrap[i];
               if (dact[i] == '0)
                  SQW[i] <= 1'b0;
               else if (adv[i])
                  SQW[i] <= sqw_level(cnt_nxt[i], dact[i]);
               if (wrap[i] || (dact[i] == '0)) begin
                  dact[i]     <= dsh[i];
                  DIV_PEND[i] <= 1'b0;
               end
               // A write landing on a wrap stays pending for the following wrap.
               if (wr_hit[i]) begin
                  dsh[i]      <= DIV_DATA;
                  DIV_PEND[i] <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_clkgen_multi.sv
// Bench for clkgen_multi: a free-running and a cascaded instance share the
// stimulus and are checked each cycle against a phase-count reference model.
module tb_clkgen_multi;

   logic       clk;
   logic       rst, en, sync, we;
   logic [1:0] sel;
   logic [7:0] data;
   logic [2:0] t0, q0, p0, t1, q1, p1;

   int total = 0;
   int bad   = 0;

   // Model state per instance (0 = free-running, 1 = cascaded) and channel.
   int mc [2][3];
   int md [2][3];
   int ms [2][3];
   bit mp [2][3];
   bit mt [2][3];
   bit mq [2][3];
   int init_tab [2][3] = '{'{4, 5, 1}, '{4, 2, 3}};

   clkgen_multi #(.NCH(3), .WIDTH(8), .DIV_INIT({8'd1, 8'd5, 8'd4}), .CASCADE(1'b0)) dut0 (
      .CLK(clk), .RST(rst), .EN(en), .SYNC(sync), .DIV_WE(we), .DIV_SEL(sel),
      .DIV_DATA(data), .TICK(t0), .SQW(q0), .DIV_PEND(p0));

   clkgen_multi #(.NCH(3), .WIDTH(8), .DIV_INIT({8'd3, 8'd2, 8'd4}), .CASCADE(1'b1)) dut1 (
      .CLK(clk), .RST(rst), .EN(en), .SYNC(sync), .DIV_WE(we), .DIV_SEL(sel),
      .DIV_DATA(data), .TICK(t1), .SQW(q1), .DIV_PEND(p1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_edge(input int k);
      bit carry;
      carry = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bit adv, wr, wrapped;
         int nc;
         adv     = en && (k == 0 || i == 0 || carry);
         wr      = we && (int'(sel) == i);
         wrapped = 1'b0;
         if (rst) begin
            mc[k][i] = 0; md[k][i] = init_tab[k][i]; ms[k][i] = init_tab[k][i];
            mp[k][i] = 0; mt[k][i] = 0; mq[k][i] = 0;
         end else if (sync) begin
            mc[k][i] = 0; mt[k][i] = 0; mq[k][i] = 0; mp[k][i] = 0;
            if (wr) ms[k][i] = int'(data);
            md[k][i] = ms[k][i];
         end else begin
            if (md[k][i] == 0) begin
               mc[k][i] = 0; mt[k][i] = 0; mq[k][i] = 0;
            end else if (adv) begin
               nc       = (mc[k][i] + 1) % md[k][i];
               wrapped  = (nc == 0);
               mc[k][i] = nc;
               mt[k][i] = wrapped;
               mq[k][i] = (nc >= (md[k][i] + 1) / 2);
            end else begin
               mt[k][i] = 0;
            end
            if (wrapped || md[k][i] == 0) begin
               md[k][i] = ms[k][i];
               mp[k][i] = 0;
            end
            if (wr) begin
               ms[k][i] = int'(data);
               mp[k][i] = 1;
            end
         end
         carry = wrapped;
      end
   endtask

   function automatic logic [8:0] exp_all(input int k);
      logic [8:0] v;
      v = '0;
      for (int i = 0; i < 3; i++) begin
         v[i]     = mt[k][i];
         v[3 + i] = mq[k][i];
         v[6 + i] = mp[k][i];
      end
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      model_edge(0);
      model_edge(1);
      #1;
   endtask

   task automatic test_reset();
      rst = 1; en = 1; sync = 0; we = 0; sel = 0; data = 0;
      step();
      step();
      total++;
      if ({p0, q0, t0} !== 9'd0) begin
         bad++; $display("FAIL reset_dut0 got=%b exp=%b", {p0, q0, t0}, 9'd0);
      end
      total++;
      if ({p1, q1, t1} !== 9'd0) begin
         bad++; $display("FAIL reset_dut1 got=%b exp=%b", {p1, q1, t1}, 9'd0);
      end
      rst = 0;
   endtask

   task automatic test_free_run();
      int n_t0, n_t1, n_t2, n_q0;
      n_t0 = 0; n_t1 = 0; n_t2 = 0; n_q0 = 0;
      en = 1;
      for (int c = 1; c <= 20; c++) begin
         step();
         n_t0 += int'(t0[0]); n_t1 += int'(t0[1]); n_t2 += int'(t0[2]); n_q0 += int'(q0[0]);
         total++;
         if ({p0, q0, t0} !== exp_all(0)) begin
            bad++; $display("FAIL free_run0 cyc=%0d got=%b exp=%b", c, {p0, q0, t0}, exp_all(0));
         end
         total++;
         if ({p1, q1, t1} !== exp_all(1)) begin
            bad++; $display("FAIL free_run1 cyc=%0d got=%b exp=%b", c, {p1, q1, t1}, exp_all(1));
         end
      end
      total++;
      if (n_t0 != 5 || n_t1 != 4 || n_t2 != 20 || n_q0 != 10) begin
         bad++; $display("FAIL free_run_counts got=%0d/%0d/%0d/%0d exp=5/4/20/10", n_t0, n_t1, n_t2, n_q0);
      end
   endtask

   task automatic test_en_freeze();
      logic [2:0] q_hold;
      step();
      step();
      q_hold = q0;
      en = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         total++;
         if (t0 !== 3'b000 || q0 !== q_hold) begin
            bad++; $display("FAIL en_freeze cyc=%0d got=%b/%b exp=000/%b", c, t0, q0, q_hold);
         end
         total++;
         if ({p1, q1, t1} !== exp_all(1)) begin
            bad++; $display("FAIL en_freeze1 cyc=%0d got=%b exp=%b", c, {p1, q1, t1}, exp_all(1));
         end
      end
      en = 1;
      for (int c = 0; c < 12; c++) begin
         step();
         total++;
         if ({p0, q0, t0} !== exp_all(0)) begin
            bad++; $display("FAIL en_resume0 cyc=%0d got=%b exp=%b", c, {p0, q0, t0}, exp_all(0));
         end
      end
   endtask

   task automatic test_div_write();
      int n, nt;
      for (n = 0; n < 10 && mc[0][0] != 1; n++) step();
      total++;
      if (mc[0][0] != 1) begin
         bad++; $display("FAIL div_write_wait got=%0d exp=1", mc[0][0]);
      end
      we = 1; sel = 0; data = 8'd2;
      step();
      we = 0;
      total++;
      if (p0[0] !== 1'b1) begin
         bad++; $display("FAIL div_write_pend got=%b exp=1", p0[0]);
      end
      step();
      total++;
      if (p0[0] !== 1'b1 || t0[0] !== 1'b0) begin
         bad++; $display("FAIL div_write_hold got=%b%b exp=10", p0[0], t0[0]);
      end
      step();
      total++;
      if (p0[0] !== 1'b0 || t0[0] !== 1'b1) begin
         bad++; $display("FAIL div_write_apply got=%b%b exp=01", p0[0], t0[0]);
      end
      nt = 0;
      for (int c = 0; c < 8; c++) begin
         step();
         nt += int'(t0[0]);
         total++;
         if ({p0, q0, t0} !== exp_all(0)) begin
            bad++; $display("FAIL div_write_run cyc=%0d got=%b exp=%b", c, {p0, q0, t0}, exp_all(0));
         end
      end
      total++;
      if (nt != 4) begin
         bad++; $display("FAIL div_write_period got=%0d exp=4", nt);
      end
   endtask

   task automatic test_wrap_write();
      int n, nt;
      for (n = 0; n < 10 && mc[0][1] != 4; n++) step();
      we = 1; sel = 1; data = 8'd3;
      step();
      we = 0;
      total++;
      if (t0[1] !== 1'b1 || p0[1] !== 1'b1) begin
         bad++; $display("FAIL wrap_write_same got=%b%b exp=11", t0[1], p0[1]);
      end
      for (int c = 0; c < 4; c++) step();
      total++;
      if (t0[1] !== 1'b0 || p0[1] !== 1'b1) begin
         bad++; $display("FAIL wrap_write_old got=%b%b exp=01", t0[1], p0[1]);
      end
      step();
      total++;
      if (t0[1] !== 1'b1 || p0[1] !== 1'b0) begin
         bad++; $display("FAIL wrap_write_next got=%b%b exp=10", t0[1], p0[1]);
      end
      nt = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         nt += int'(t0[1]);
      end
      total++;
      if (nt != 2) begin
         bad++; $display("FAIL wrap_write_period got=%0d exp=2", nt);
      end
      we = 1; sel = 1; data = 8'd0;
      step();
      we = 0;
      for (n = 0; n < 6 && p0[1] !== 1'b0; n++) step();
      for (int c = 0; c < 10; c++) begin
         step();
         total++;
         if (t0[1] !== 1'b0 || q0[1] !== 1'b0 || {p0, q0, t0} !== exp_all(0)) begin
            bad++; $display("FAIL disabled_ch1 cyc=%0d got=%b exp=%b", c, {p0, q0, t0}, exp_all(0));
         end
      end
   endtask

   task automatic test_sync();
      int n, nt;
      for (n = 0; n < 6 && mc[0][0] != 0; n++) step();
      we = 1; sel = 0; data = 8'd6;
      step();
      we = 0; sync = 1;
      step();
      sync = 0;
      total++;
      if (t0 !== 3'b000 || q0 !== 3'b000 || p0 !== 3'b000) begin
         bad++; $display("FAIL sync_clear got=%b exp=%b", {p0, q0, t0}, 9'd0);
      end
      nt = 0;
      for (int c = 1; c <= 6; c++) begin
         step();
         nt += int'(t0[0]);
         total++;
         if ({p0, q0, t0} !== exp_all(0)) begin
            bad++; $display("FAIL sync_run cyc=%0d got=%b exp=%b", c, {p0, q0, t0}, exp_all(0));
         end
      end
      total++;
      if (nt != 1 || t0[0] !== 1'b1) begin
         bad++; $display("FAIL sync_newdiv got=%0d/%b exp=1/1", nt, t0[0]);
      end
      we = 1; sel = 2; data = 8'd2; sync = 1;
      step();
      we = 0; sync = 0;
      total++;
      if (p0[2] !== 1'b0 || t0[2] !== 1'b0) begin
         bad++; $display("FAIL sync_write got=%b%b exp=00", p0[2], t0[2]);
      end
      nt = 0;
      for (int c = 0; c < 4; c++) begin
         step();
         nt += int'(t0[2]);
      end
      total++;
      if (nt != 2) begin
         bad++; $display("FAIL sync_write_period got=%0d exp=2", nt);
      end
   endtask

   task automatic test_random();
      logic [7:0] pick [8];
      pick = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd255, 8'd7};
      for (int c = 0; c < 500; c++) begin
         rst  = ($urandom_range(0, 63) == 0);
         en   = ($urandom_range(0, 7) != 0);
         sync = ($urandom_range(0, 31) == 0);
         we   = ($urandom_range(0, 7) == 0);
         sel  = 2'($urandom_range(0, 3));
         data = ($urandom_range(0, 1) == 0) ? pick[$urandom_range(0, 7)] : 8'($urandom_range(0, 9));
         step();
         total++;
         if ({p0, q0, t0} !== exp_all(0)) begin
            bad++; $display("FAIL random0 cyc=%0d got=%b exp=%b", c, {p0, q0, t0}, exp_all(0));
         end
         total++;
         if ({p1, q1, t1} !== exp_all(1)) begin
            bad++; $display("FAIL random1 cyc=%0d got=%b exp=%b", c, {p1, q1, t1}, exp_all(1));
         end
      end
      rst = 0; en = 1; sync = 0; we = 0;
   endtask

   task automatic test_cascade();
      int n1, n2;
      rst = 1;
      step();
      rst = 0; en = 1;
      n1 = 0; n2 = 0;
      for (int c = 1; c <= 48; c++) begin
         step();
         n1 += int'(t1[1]);
         n2 += int'(t1[2]);
         total++;
         if ((t1[1] && !t1[0]) || (t1[2] && !t1[1])) begin
            bad++; $display("FAIL cascade_align cyc=%0d got=%b", c, t1);
         end
         total++;
         if ({p1, q1, t1} !== exp_all(1)) begin
            bad++; $display("FAIL cascade_run cyc=%0d got=%b exp=%b", c, {p1, q1, t1}, exp_all(1));
         end
      end
      total++;
      if (n1 != 6 || n2 != 2) begin
         bad++; $display("FAIL cascade_counts got=%0d/%0d exp=6/2", n1, n2);
      end
      for (int c = 0; c < 5; c++) step();
      rst = 1;
      step();
      rst = 0;
      total++;
      if ({p1, q1, t1, p0, q0, t0} !== 18'd0) begin
         bad++; $display("FAIL cascade_reset got=%b exp=0", {p1, q1, t1, p0, q0, t0});
      end
   endtask

   initial begin
      rst = 1; en = 0; sync = 0; we = 0; sel = 0; data = 0;
      test_reset();
      test_free_run();
      test_en_freeze();
      test_div_write();
      test_wrap_write();
      test_sync();
      test_random();
      test_cascade();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
